// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: start/a/b in, busy/done/sum/cout out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first, through a two-half-adder
// full-adder cell and a carry flip-flop; result registered on the last RUN edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [WIDTH-1:0]  a_reg, b_reg;
  // Only the WIDTH-1 previously produced sum bits need storing; the newest bit
  // is appended combinationally when the result is committed.
  logic [WIDTH-2:0]  partial_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              cout_reg;

  logic              s1, c1, c2, bit_sum, carry_next;
  logic              last_bit;
  logic [WIDTH-1:0]  sum_next;
  logic              busy, done;

  // Full adder built from two half adders.
  assign s1         = a_reg[0] ^ b_reg[0];
  assign c1         = a_reg[0] & b_reg[0];
  assign bit_sum    = s1 ^ carry_reg;
  assign c2         = s1 & carry_reg;
  assign carry_next = c1 | c2;

  assign sum_next = {bit_sum, partial_reg};
  assign last_bit = (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      partial_reg <= '0;
      carry_reg   <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= 1'b0;
            count_reg <= '0;
          end
        end
        RUN: begin
          partial_reg <= sum_next[WIDTH-1:1];
          a_reg       <= a_reg >> 1;
          b_reg       <= b_reg >> 1;
          carry_reg   <= carry_next;
          count_reg   <= count_reg + 1'b1;
          if (last_bit) begin
            sum_reg  <= sum_next;
            cout_reg <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues expected {cout,sum}, a
// negedge monitor pops and compares on every done pulse.
module tb_serial_adder;
  localparam int W = 8;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  int         done_cyc[$];
  int         cyc_cnt = 0;
  logic [W:0] held = '0;
  logic       prev_done = 1'b0;

  // Monitor: compares each done pulse against the scoreboard and checks that
  // the result registers hold between pulses.
  always @(negedge clk) begin
    logic [W:0] exp_v;
    logic [W:0] act_v;
    cyc_cnt++;
    act_v = {bus.cout, bus.sum};
    if (rst) begin
      held      = '0;
      prev_done = 1'b0;
    end else begin
      total++;
      if (bus.busy && bus.done) begin
        bad++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", bus.busy, bus.done);
      end
      if (bus.done) begin
        total++;
        if (prev_done) begin
          bad++;
          $display("FAIL done_width: done high on consecutive cycles, required 1-cycle pulse");
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got {cout,sum}=0x%0h with nothing outstanding", act_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            bad++;
            $display("FAIL result: got {cout,sum}=0x%0h required 0x%0h", act_v, exp_v);
          end else begin
            $display("op cyc=%0d sum=0x%0h cout=%0b", cyc_cnt, bus.sum, bus.cout);
          end
        end
        held = act_v;
        done_cyc.push_back(cyc_cnt);
      end else if (act_v !== held) begin
        bad++;
        $display("FAIL hold: {cout,sum}=0x%0h changed from 0x%0h without done", act_v, held);
      end
      prev_done = bus.done;
    end
  end

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Issue one operation; optionally pulse start with new operands at RUN cycle inject.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W:0] expv, input int inject);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc       = 0;
    busy_cnt  = 0;
    while (!bus.done && cyc < W + 4) begin
      if (bus.busy) busy_cnt++;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.start = (cyc == inject);
      if (cyc == inject) begin
        bus.a = '1;
        bus.b = '1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    check("latency", (W+1)'(cyc), (W+1)'(W));
    check("busy_len", (W+1)'(busy_cnt), (W+1)'(W));
    @(posedge clk);
    #1;
    check("done_fall", {8'd0, bus.done}, '0);
  endtask

  logic [W-1:0] dir_a [6] = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'hC3};
  logic [W-1:0] dir_b [6] = '{8'h3C, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h5A};
  logic [W:0]   dir_e [6] = '{9'h096, 9'h100, 9'h1FE, 9'h000, 9'h100, 9'h11D};

  initial begin
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", {bus.cout, bus.sum}, '0);
    check("rst_flags", {7'd0, bus.busy, bus.done}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_flags", {7'd0, bus.busy, bus.done}, '0);

    for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], dir_e[i], -1);

    // start pulsed mid-RUN with different operands must be ignored
    run_op(8'h10, 8'h20, 9'h030, 3);

    // asynchronous reset aborts an operation in flight
    run_op(8'h80, 8'h80, 9'h100, -1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    exp_q.push_back(9'h003);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_sum", {bus.cout, bus.sum}, '0);
    check("abort_flags", {7'd0, bus.busy, bus.done}, '0);
    void'(exp_q.pop_back());
    @(negedge clk);
    #2;
    rst = 1'b0;
    run_op(8'h03, 8'h04, 9'h007, -1);

    // start held high: back-to-back operations every W+2 cycles
    done_cyc.delete();
    repeat (3) exp_q.push_back(9'h080);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h7F;
    bus.b     = 8'h01;
    repeat (30) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    check("held_count", (W+1)'(done_cyc.size()), 9'd3);
    if (done_cyc.size() == 3) begin
      check("held_gap1", (W+1)'(done_cyc[1] - done_cyc[0]), (W+1)'(W + 2));
      check("held_gap2", (W+1)'(done_cyc[2] - done_cyc[1]), (W+1)'(W + 2));
    end

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, {1'b0, ra} + {1'b0, rb}, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain", (W+1)'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
